// File: rtl/demux4_loader.sv
// demux4_loader: scatters a four-word valid/ready stream into bank registers a..d
// through a rotating one-hot select, flagging the bank once all four are fresh.
module demux4_loader #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             in_ready_o,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic [WIDTH-1:0] c_o,
   output logic [WIDTH-1:0] d_o,
   output logic [3:0]       demux_sel_o,
   output logic             flag_o,
   output logic             done_o
);
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
   logic [3:0]       sel_q;
   logic             flag_q, done_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         sel_q   <= 4'b0000;
         flag_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               state_q <= start_i ? LOAD : IDLE;
               if (start_i) begin
                  sel_q  <= 4'b0001;
                  flag_q <= 1'b0;
               end
            end
            LOAD: if (in_valid_i) begin
               if (sel_q[0]) a_q <= in_data_i;
               if (sel_q[1]) b_q <= in_data_i;
               if (sel_q[2]) c_q <= in_data_i;
               if (sel_q[3]) d_q <= in_data_i;
               // shifting 1000 out leaves 0000, which is the not-loading select
               sel_q <= {sel_q[2:0], 1'b0};
               if (sel_q[3]) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  flag_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign in_ready_o  = (state_q == LOAD);
   assign a_o         = a_q;
   assign b_o         = b_q;
   assign c_o         = c_q;
   assign d_o         = d_q;
   assign demux_sel_o = sel_q;
   assign flag_o      = flag_q;
   assign done_o      = done_q;
endmodule

// File: tb/tb_demux4_loader.sv
// tb_demux4_loader: table-driven bank loads with a done-time scoreboard and a
// per-cycle reference of the bank registers, select, flag and ready.
module tb_demux4_loader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic [31:0] in_data_i = '0;
   logic        in_ready_o;
   logic [31:0] a_o, b_o, c_o, d_o;
   logic [3:0]  demux_sel_o;
   logic        flag_o, done_o;

   demux4_loader #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .in_valid_i(in_valid_i),
      .in_data_i(in_data_i), .in_ready_o(in_ready_o), .a_o(a_o), .b_o(b_o),
      .c_o(c_o), .d_o(d_o), .demux_sel_o(demux_sel_o), .flag_o(flag_o),
      .done_o(done_o)
   );

   always #5 clk = ~clk;

   typedef logic [3:0][31:0] bank_t;
   typedef struct packed {
      bank_t           w;
      logic [3:0][3:0] gap;
      logic [3:0]      restart_at;
      logic [7:0]      exp_done;
      logic            chain;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   bank_t       sb[$];
   logic [31:0] em[4];
   logic        eflag;
   logic [31:0] dreg[4];
   vec_t        vecs[4];

   assign dreg[0] = a_o;
   assign dreg[1] = b_o;
   assign dreg[2] = c_o;
   assign dreg[3] = d_o;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_regs(input string name);
      for (int k = 0; k < 4; k++) chk(name, dreg[k], em[k]);
   endtask

   // Completed banks are compared against the scoreboard in the done cycle.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         assert ($onehot0(demux_sel_o)) else begin
            errors++;
            $display("FAIL sel_onehot0: got %b", demux_sel_o);
         end
         if (done_o) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done: got done=1 expected no pending bank at %0t", $time);
            end else begin
               bank_t e;
               e = sb.pop_front();
               chk("sb_a", a_o, e[0]);
               chk("sb_b", b_o, e[1]);
               chk("sb_c", c_o, e[2]);
               chk("sb_d", d_o, e[3]);
               chk("sb_flag", flag_o, 1);
            end
         end
      end
   end

   task automatic run_bank(input vec_t v);
      int   cyc, i, g, dc;
      logic acc;
      start_i = 1'b1;
      sb.push_back(v.w);
      step();
      start_i = 1'b0;
      eflag = 1'b0;
      cyc = 1;
      i = 0;
      g = 0;
      dc = -1;
      while (dc < 0 && cyc < 40) begin
         if (done_o) dc = cyc;
         else begin
            chk("load_sel", demux_sel_o, 4'b0001 << i);
            chk("load_ready", in_ready_o, 1);
            chk("load_flag", flag_o, 0);
            chk_regs("load_reg");
            start_i = (cyc == int'(v.restart_at));
            acc = (i < 4 && g == 0);
            in_valid_i = acc;
            in_data_i = acc ? v.w[i] : $urandom();
            step();
            start_i = 1'b0;
            in_valid_i = 1'b0;
            if (acc) begin
               em[i] = v.w[i];
               g = int'(v.gap[i]);
               i++;
            end else if (g > 0) g--;
            cyc++;
         end
      end
      chk("done_cycle", dc, 32'(v.exp_done));
      if (dc > 0) begin
         eflag = 1'b1;
         chk("done_flag", flag_o, 1);
         chk("done_ready", in_ready_o, 0);
         chk("done_sel", demux_sel_o, 0);
         chk_regs("done_reg");
      end
   endtask

   task automatic idle_check(input string name);
      chk(name, done_o, 0);
      chk(name, flag_o, eflag);
      chk(name, in_ready_o, 0);
      chk(name, demux_sel_o, 0);
      chk_regs(name);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{w: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                  gap: 16'h0000, restart_at: 4'd0, exp_done: 8'd5, chain: 1'b0};
      vecs[1] = '{w: {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555},
                  gap: 16'h0000, restart_at: 4'd2, exp_done: 8'd5, chain: 1'b0};
      vecs[2] = '{w: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                  gap: 16'h0020, restart_at: 4'd0, exp_done: 8'd7, chain: 1'b1};
      vecs[3] = '{w: {32'h12345678, 32'h0BADF00D, 32'hCAFEF00D, 32'hDEADBEEF},
                  gap: 16'h0301, restart_at: 4'd0, exp_done: 8'd9, chain: 1'b0};
      for (int k = 0; k < 4; k++) em[k] = '0;
      eflag = 1'b0;
      // reset for two edges, then ten idle cycles
      step();
      step();
      rst = 1'b0;
      for (int n = 0; n < 10; n++) begin
         idle_check("reset_idle");
         step();
      end
      // vec 2 chains: the next bank starts in its DONE cycle
      for (int k = 0; k < 4; k++) begin
         run_bank(vecs[k]);
         if (!vecs[k].chain) begin
            step();
            idle_check("post_done_idle");
         end
      end
      // reset after two accepts discards the partial bank
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      in_valid_i = 1'b1;
      in_data_i = 32'hAAAA0001;
      step();
      in_data_i = 32'hAAAA0002;
      step();
      in_valid_i = 1'b0;
      chk("mid_b", b_o, 32'hAAAA0002);
      chk("mid_sel", demux_sel_o, 4'b0100);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) em[k] = '0;
      eflag = 1'b0;
      for (int n = 0; n < 3; n++) begin
         idle_check("mid_rst_idle");
         step();
      end
      run_bank(vecs[3]);
      step();
      idle_check("final_idle");
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
